// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128 key schedule.
//   Expands a 128-bit cipher key into the 44-word (1408-bit) expanded key.
//   One word per clock by default. Defining KEYEXP_FAST_EN builds a variant
//   that writes a whole four-word round per clock.
//
// Ports:
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request expansion (sampled only while busy=0)
//   key     in   128   cipher key, FIPS word k at key[32*k+31 -: 32]
//   w       out  1408  expanded key, FIPS word i at w[32*i+31 -: 32]
//   w_valid out  1     w holds a complete schedule for the last accepted key
//   busy    out  1     expansion in progress
//   done    out  1     one-cycle pulse after the last word is written
//
// Optional feature macro: KEYEXP_FAST_EN
module key_expansion_seq #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [127:0]  key,
  output logic [1407:0] w,
  output logic          w_valid,
  output logic          busy,
  output logic          done
);

  localparam int NW = 4 * (NR + 1);

`ifdef KEYEXP_FAST_EN
  localparam logic [5:0] LAST_IDX = 6'(NW - 4);
  localparam logic [5:0] STEP     = 6'd4;
`else
  localparam logic [5:0] LAST_IDX = 6'(NW - 1);
  localparam logic [5:0] STEP     = 6'd1;
`endif

  generate
    if (NK != 4 || NR != 10) begin : g_bad_param
      $error("key_expansion_seq supports only NK=4, NR=10 (AES-128)");
    end
  endgenerate

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {~x, 3'b000};  // (255 - x) * 8
    return SBOX_TABLE[pos +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  typedef enum logic [0:0] {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t      state;
  logic [5:0]  counter;
  logic [5:0]  idx;
  logic [10:0] base;
  logic [31:0] w_m1;
  logic [31:0] w_m4;
  logic [31:0] g_word;
  logic [31:0] n0;
`ifdef KEYEXP_FAST_EN
  logic [31:0] w_m2;
  logic [31:0] w_m3;
  logic [31:0] n1;
  logic [31:0] n2;
  logic [31:0] n3;
`endif

  // Fetch the previous words and compute the word(s) written at this index
  always_comb begin
    // Clamp while idle so the backward part-selects stay inside w.
    idx    = (counter < 6'd4) ? 6'd4 : counter;
    base   = {idx, 5'b00000};
    w_m1   = w[base - 11'd32 +: 32];
    w_m4   = w[base - 11'd128 +: 32];
    g_word = sub_word({w_m1[23:0], w_m1[31:24]}) ^ {rcon(idx[5:2]), 24'h000000};
`ifdef KEYEXP_FAST_EN
    // Whole round: only the first word gets RotWord/SubWord/rcon.
    w_m2   = w[base - 11'd64 +: 32];
    w_m3   = w[base - 11'd96 +: 32];
    n0     = w_m4 ^ g_word;
    n1     = w_m3 ^ n0;
    n2     = w_m2 ^ n1;
    n3     = w_m1 ^ n2;
`else
    n0     = w_m4 ^ ((idx[1:0] == 2'b00) ? g_word : w_m1);
`endif
  end

  // Handshake FSM and expanded-key register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      w       <= {1408{1'b0}};
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      counter <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w[127:0] <= key;
            counter  <= 6'd4;
            busy     <= 1'b1;
            w_valid  <= 1'b0;
            state    <= EXPAND;
          end
        end
        EXPAND: begin
`ifdef KEYEXP_FAST_EN
          w[base +: 128] <= {n3, n2, n1, n0};
`else
          w[base +: 32] <= n0;
`endif
          if (counter == LAST_IDX) begin
            // Counter holds at its final value so it never passes 43.
            busy    <= 1'b0;
            done    <= 1'b1;
            w_valid <= 1'b1;
            state   <= IDLE;
          end else begin
            counter <= counter + STEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
